// File: rtl/key_debounce_ctrl.sv
// Debounced key input controller with an Avalon-MM slave register interface.
// Each raw active-low key is synchronized, debounced with a per-bit counter,
// and a press (debounced 1->0) latches a bit in an edge-capture register that
// can raise a maskable level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address: 0 DATA, 1 IRQMASK, 2 EDGECAP, 3 reserved
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (only the low WIDTH bits are used)
//   readdata   registered read data, one cycle after the address is presented
//   in_port    raw asynchronous keys, 0 = pressed
//   irq        registered level interrupt, |(edgecapture & irqmask)
module key_debounce_ctrl #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_prev;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] irqmask;
   logic [CNT_W-1:0] cnt [WIDTH];

   logic             wr_en_c;
   logic [WIDTH-1:0] press_c;
   logic [WIDTH-1:0] clr_c;
   logic [WIDTH-1:0] edgecap_next_c;
   logic [31:0]      rd_mux_c;
   logic             unused_wdata_c;

   // Write decode, press detection and read mux
   always_comb begin
      wr_en_c        = chipselect & ~write_n;
      press_c        = stable_prev & ~stable;
      clr_c          = '0;
      if (wr_en_c && (address == ADDR_EDGECAP)) begin
         clr_c = writedata[WIDTH-1:0];
      end
      // A press arriving with a clear of the same bit keeps the bit set
      edgecap_next_c = (edgecap & ~clr_c) | press_c;
      case (address)
         ADDR_DATA:    rd_mux_c = 32'(stable);
         ADDR_IRQMASK: rd_mux_c = 32'(irqmask);
         ADDR_EDGECAP: rd_mux_c = 32'(edgecap);
         default:      rd_mux_c = '0;
      endcase
   end

   // Upper writedata bits are architecturally ignored
   assign unused_wdata_c = ^writedata;

   // Two-flop synchronizer; resets to released so reset exit creates no press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: any return to the stable level restarts the count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable      <= '1;
         stable_prev <= '1;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable_prev <= stable;
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Register file, read data and interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap  <= '0;
         irqmask  <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         edgecap  <= edgecap_next_c;
         if (wr_en_c && (address == ADDR_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
         end
         readdata <= rd_mux_c;
         irq      <= |(edgecap & irqmask);
      end
   end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
module tb_key_debounce_ctrl;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int n_checks;
   int n_fail;

   key_debounce_ctrl #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  keys;
      logic [1:0]  addr;
      logic        cs;
      logic        wr;
      logic [31:0] wdata;
      int          cycles;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Inputs held for v.cycles edges; a write strobe lasts only the first edge
   task automatic apply(input vec_t v);
      in_port    = v.keys;
      address    = v.addr;
      chipselect = v.cs;
      write_n    = ~v.wr;
      writedata  = v.wdata;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      if (v.cycles > 1) tick(v.cycles - 1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      //          keys   addr cs    wr    wdata          cyc exp_rd       irq
      vecs[0]  = '{4'hF, 2'd0, 1'b0, 1'b0, 32'h0,         3, 32'h0000000F, 1'b0};
      vecs[1]  = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0,         5, 32'h0000000F, 1'b0};
      vecs[2]  = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0,         2, 32'h0000000E, 1'b0};
      vecs[3]  = '{4'hE, 2'd2, 1'b0, 1'b0, 32'h0,         3, 32'h00000001, 1'b0};
      vecs[4]  = '{4'hE, 2'd1, 1'b1, 1'b1, 32'hFFFFFFF1,  2, 32'h00000001, 1'b1};
      vecs[5]  = '{4'hE, 2'd2, 1'b1, 1'b1, 32'h00000001,  1, 32'h00000001, 1'b1};
      vecs[6]  = '{4'hE, 2'd2, 1'b0, 1'b0, 32'h0,         1, 32'h00000000, 1'b0};
      vecs[7]  = '{4'hC, 2'd0, 1'b0, 1'b0, 32'h0,         3, 32'h0000000E, 1'b0};
      vecs[8]  = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0,         8, 32'h0000000E, 1'b0};
      vecs[9]  = '{4'hE, 2'd2, 1'b0, 1'b0, 32'h0,         1, 32'h00000000, 1'b0};
      vecs[10] = '{4'h6, 2'd0, 1'b0, 1'b0, 32'h0,         8, 32'h00000006, 1'b0};
      vecs[11] = '{4'h6, 2'd2, 1'b0, 1'b0, 32'h0,         1, 32'h00000008, 1'b0};
      vecs[12] = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0,         8, 32'h0000000E, 1'b0};
      vecs[13] = '{4'hE, 2'd2, 1'b0, 1'b0, 32'h0,         1, 32'h00000008, 1'b0};
      vecs[14] = '{4'hE, 2'd2, 1'b1, 1'b1, 32'h00000008,  2, 32'h00000000, 1'b0};
      vecs[15] = '{4'hE, 2'd0, 1'b1, 1'b1, 32'h00000000,  2, 32'h0000000E, 1'b0};
      vecs[16] = '{4'hE, 2'd3, 1'b1, 1'b1, 32'hFFFFFFFF,  2, 32'h00000000, 1'b0};
      vecs[17] = '{4'hE, 2'd1, 1'b0, 1'b1, 32'h0000000F,  2, 32'h00000001, 1'b0};

      // Reset state
      reset_n    = 1'b0;
      in_port    = 4'hF;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      #1;
      check("reset_rd", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      tick(2);
      reset_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i]);
         check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      end

      // Press of key1 with an EDGECAP clear of bit1 on the same edge
      in_port = 4'hC;
      address = 2'd0;
      tick(6);
      check("same_cycle_pre_rd", readdata, 32'h0000000E);
      address    = 2'd2;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'h00000002;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      tick(1);
      check("same_cycle_edgecap", readdata, 32'h00000002);
      check("same_cycle_irq", {31'b0, irq}, 32'h0);

      // Unmask key1 so irq is high before the reset test
      address    = 2'd1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'h00000003;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      tick(1);
      check("mask3_irq", {31'b0, irq}, 32'h1);

      // Reset in the middle of a key2 count
      address = 2'd2;
      in_port = 4'h8;
      tick(4);
      check("pre_reset_rd", readdata, 32'h00000002);
      check("pre_reset_irq", {31'b0, irq}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("async_reset_rd", readdata, 32'h0);
      check("async_reset_irq", {31'b0, irq}, 32'h0);
      in_port = 4'hF;
      tick(2);
      reset_n = 1'b1;
      address = 2'd0;
      tick(8);
      check("post_reset_data", readdata, 32'h0000000F);
      address = 2'd2;
      tick(1);
      check("post_reset_edgecap", readdata, 32'h0);
      check("post_reset_irq", {31'b0, irq}, 32'h0);
      address = 2'd1;
      tick(1);
      check("post_reset_mask", readdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
